// File: rtl/ftq_multi_update_pkg.sv
// Shared types and helpers for the multi-update fetch target queue:
// core config type, replay mask and popcount.
package ftq_multi_update_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned INSTR_PER_FETCH;
        int unsigned LOG2_INSTR_PER_FETCH;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{
        VLEN: 32,
        INSTR_PER_FETCH: 4,
        LOG2_INSTR_PER_FETCH: 2
    };

    localparam int unsigned FTQ_DEPTH = 8;
    localparam int unsigned DEPTH_W   = $clog2(FTQ_DEPTH);
    localparam int unsigned MAX_IPF   = 8;

    // Slots at or above the replay position are re-fetched after an
    // instruction-queue overflow and must not be counted again.
    function automatic logic [MAX_IPF-1:0] replay_mask(
        input logic       ovf,
        input logic [2:0] pos
    );
        logic [MAX_IPF-1:0] m;
        m = {MAX_IPF{ovf}};
        return m << pos;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/ftq_multi_update_lane_map.sv
// Maps update lanes onto head entries by remaining count.
// In: head counts, usage, lane count. Out: lane offsets, pops, partial drain.
module ftq_multi_update_lane_map #(
    parameter int unsigned NR_UPDATE = 2,
    parameter int unsigned CW        = 3,
    parameter int unsigned UW        = 4,
    parameter int unsigned OW        = 1,
    parameter int unsigned PW        = 2
) (
    input  logic [NR_UPDATE-1:0][CW-1:0] rem_i,
    input  logic [UW-1:0]                usage_i,
    input  logic [PW-1:0]                n_i,
    output logic [NR_UPDATE-1:0]         lane_vld_o,
    output logic [NR_UPDATE-1:0][OW-1:0] lane_off_o,
    output logic [PW-1:0]                pop_cnt_o,
    output logic                         part_vld_o,
    output logic [OW-1:0]                part_off_o,
    output logic [CW-1:0]                part_rem_o,
    output logic                         underflow_o
);

    localparam int unsigned SW = CW + 2;

    logic [NR_UPDATE-1:0]         vld;
    logic [NR_UPDATE-1:0][SW-1:0] sum;
    logic [SW-1:0]                acc;
    logic [SW-1:0]                n_ext;

    always_comb begin
        acc   = '0;
        n_ext = SW'(n_i);
        for (int j = 0; j < NR_UPDATE; j++) begin
            vld[j] = (UW'(j) < usage_i);
            if (vld[j]) begin
                acc = acc + SW'(rem_i[j]);
            end
            sum[j] = acc;
        end
        underflow_o = (n_ext > acc);
    end

    // Descending scans let the smallest matching entry win.
    always_comb begin
        lane_vld_o = '0;
        lane_off_o = '0;
        for (int k = 0; k < NR_UPDATE; k++) begin
            for (int j = NR_UPDATE - 1; j >= 0; j--) begin
                if (vld[j] && (SW'(k) < sum[j])) begin
                    lane_vld_o[k] = 1'b1;
                    lane_off_o[k] = OW'(j);
                end
            end
        end
    end

    always_comb begin
        pop_cnt_o  = '0;
        part_vld_o = 1'b0;
        part_off_o = '0;
        part_rem_o = '0;
        for (int j = 0; j < NR_UPDATE; j++) begin
            if (vld[j] && (sum[j] <= n_ext)) begin
                pop_cnt_o = pop_cnt_o + PW'(1);
            end
        end
        for (int j = NR_UPDATE - 1; j >= 0; j--) begin
            if (vld[j] && (sum[j] > n_ext)) begin
                part_vld_o = 1'b1;
                part_off_o = OW'(j);
                part_rem_o = CW'(sum[j] - n_ext);
            end
        end
    end

endmodule

// File: rtl/ftq_multi_update.sv
// Fetch target queue returning branch metadata to several update lanes.
// Push: fetch-block slots/metadata. Pop: upd_valid_i lanes. Status: usage/flags.
module ftq_multi_update
    import ftq_multi_update_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg       = cva6_cfg_empty,
    parameter type         bp_metadata_t = logic,
    parameter int unsigned DEPTH         = FTQ_DEPTH,
    parameter int unsigned NR_UPDATE     = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                debug_mode_i,
    input  logic [CVA6Cfg.VLEN-1:0]             replay_addr_i,
    input  logic                                serving_unaligned_i,
    input  logic                                iq_overflow_i,
    input  logic [CVA6Cfg.INSTR_PER_FETCH-1:0]  valid_i,
    input  logic [CVA6Cfg.INSTR_PER_FETCH-1:0]  is_branch_i,
    input  logic [CVA6Cfg.INSTR_PER_FETCH-1:0]  taken_cf_i,
    input  bp_metadata_t                        bp_metadata_i,
    input  logic [NR_UPDATE-1:0]                upd_valid_i,
    output bp_metadata_t [NR_UPDATE-1:0]        bp_metadata_o,
    output logic [NR_UPDATE-1:0]                is_unaligned_o,
    output logic [$clog2(DEPTH):0]              usage_o,
    output logic                                overflow_o,
    output logic                                underflow_o
);

    localparam int unsigned IPF  = CVA6Cfg.INSTR_PER_FETCH;
    localparam int unsigned LIPF = CVA6Cfg.LOG2_INSTR_PER_FETCH;
    localparam int unsigned VLEN = CVA6Cfg.VLEN;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned UW   = AW + 1;
    localparam int unsigned CW   = LIPF + 1;
    localparam int unsigned OW   = (NR_UPDATE > 1) ? $clog2(NR_UPDATE) : 1;
    localparam int unsigned PW   = $clog2(NR_UPDATE + 1);

    typedef struct packed {
        bp_metadata_t    meta;
        logic            is_unaligned;
        logic [CW-1:0]   cnt;
    } ftq_entry_t;

    ftq_entry_t mem_q [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [UW-1:0] usage_q;

    logic [LIPF-1:0]    replay_pos;
    logic [MAX_IPF-1:0] replay_full;
    logic [IPF-1:0]     is_replay;
    logic [IPF-1:0]     vb;
    logic               prior_taken;
    logic [CW-1:0]      cnt;
    logic               push;

    logic [PW-1:0]                n_upd;
    logic [NR_UPDATE-1:0][CW-1:0] rem;
    logic [NR_UPDATE-1:0]         lane_vld;
    logic [NR_UPDATE-1:0][OW-1:0] lane_off;
    logic [PW-1:0]                pop_cnt;
    logic                         part_vld;
    logic [OW-1:0]                part_off;
    logic [CW-1:0]                part_rem;
    logic                         map_underflow;

    logic unused_addr;
    assign unused_addr = ^{replay_addr_i[VLEN-1:LIPF+1], replay_addr_i[0]};

    // A block resuming on the second half of an unaligned instruction
    // replays from slot 0 regardless of the address.
    assign replay_pos = serving_unaligned_i ? '0 : replay_addr_i[LIPF:1];
    assign replay_full = replay_mask(iq_overflow_i, 3'(replay_pos));
    assign is_replay   = replay_full[IPF-1:0];

    // Branches behind a predicted-taken slot never execute.
    always_comb begin
        prior_taken = 1'b0;
        for (int i = 0; i < IPF; i++) begin
            vb[i] = is_branch_i[i] & ~is_replay[i] & ~prior_taken;
            prior_taken = prior_taken | (valid_i[i] & taken_cf_i[i]);
        end
    end

    assign cnt = CW'(popcount8(8'(vb)));

    assign push = (cnt != '0) && (usage_q < UW'(DEPTH)) && !iq_overflow_i;

    assign overflow_o = (cnt != '0) && (usage_q == UW'(DEPTH));

    assign n_upd = PW'(popcount8(8'(upd_valid_i)));

    always_comb begin
        for (int j = 0; j < NR_UPDATE; j++) begin
            rem[j] = mem_q[head_q + AW'(j)].cnt;
        end
    end

    ftq_multi_update_lane_map #(
        .NR_UPDATE (NR_UPDATE),
        .CW        (CW),
        .UW        (UW),
        .OW        (OW),
        .PW        (PW)
    ) i_lane_map (
        .rem_i       (rem),
        .usage_i     (usage_q),
        .n_i         (n_upd),
        .lane_vld_o  (lane_vld),
        .lane_off_o  (lane_off),
        .pop_cnt_o   (pop_cnt),
        .part_vld_o  (part_vld),
        .part_off_o  (part_off),
        .part_rem_o  (part_rem),
        .underflow_o (map_underflow)
    );

    always_comb begin
        bp_metadata_o  = '0;
        is_unaligned_o = '0;
        for (int k = 0; k < NR_UPDATE; k++) begin
            if (upd_valid_i[k] && lane_vld[k]) begin
                bp_metadata_o[k]  = mem_q[head_q + AW'(lane_off[k])].meta;
                is_unaligned_o[k] = mem_q[head_q + AW'(lane_off[k])].is_unaligned;
            end
        end
    end

    assign underflow_o = map_underflow & ~debug_mode_i;
    assign usage_o     = usage_q;

    // The partially drained entry is always below usage_q, so it never
    // aliases the tail slot written by an accepted push.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            usage_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            usage_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= '{
                    meta: bp_metadata_i,
                    is_unaligned: serving_unaligned_i,
                    cnt: cnt
                };
                tail_q <= tail_q + AW'(1);
            end
            if (!debug_mode_i) begin
                if (part_vld) begin
                    mem_q[head_q + AW'(part_off)].cnt <= part_rem;
                end
                head_q  <= head_q + AW'(pop_cnt);
                usage_q <= usage_q + UW'(push) - UW'(pop_cnt);
            end else begin
                usage_q <= usage_q + UW'(push);
            end
        end
    end

`ifndef SYNTHESIS
    a_upd_contig : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        ((upd_valid_i & (upd_valid_i + NR_UPDATE'(1))) == '0)
    );
`endif

endmodule

// File: tb/tb_ftq_multi_update.sv
// Directed bench for ftq_multi_update: push qualification, lane mapping,
// multi-entry consumption, overflow/underflow, debug and flush.
module tb_ftq_multi_update;
    import ftq_multi_update_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             debug_mode_i;
    logic [31:0]      replay_addr_i;
    logic             serving_unaligned_i;
    logic             iq_overflow_i;
    logic [3:0]       valid_i;
    logic [3:0]       is_branch_i;
    logic [3:0]       taken_cf_i;
    logic [7:0]       bp_metadata_i;
    logic [1:0]       upd_valid_i;
    logic [1:0][7:0]  bp_metadata_o;
    logic [1:0]       is_unaligned_o;
    logic [3:0]       usage_o;
    logic             overflow_o;
    logic             underflow_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    ftq_multi_update #(
        .CVA6Cfg       (cva6_cfg_empty),
        .bp_metadata_t (logic [7:0]),
        .DEPTH         (8),
        .NR_UPDATE     (2)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .debug_mode_i        (debug_mode_i),
        .replay_addr_i       (replay_addr_i),
        .serving_unaligned_i (serving_unaligned_i),
        .iq_overflow_i       (iq_overflow_i),
        .valid_i             (valid_i),
        .is_branch_i         (is_branch_i),
        .taken_cf_i          (taken_cf_i),
        .bp_metadata_i       (bp_metadata_i),
        .upd_valid_i         (upd_valid_i),
        .bp_metadata_o       (bp_metadata_o),
        .is_unaligned_o      (is_unaligned_o),
        .usage_o             (usage_o),
        .overflow_o          (overflow_o),
        .underflow_o         (underflow_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush_i             = 1'b0;
        debug_mode_i        = 1'b0;
        replay_addr_i       = '0;
        serving_unaligned_i = 1'b0;
        iq_overflow_i       = 1'b0;
        valid_i             = '0;
        is_branch_i         = '0;
        taken_cf_i          = '0;
        bp_metadata_i       = '0;
        upd_valid_i         = '0;
    endtask

    task automatic drive_push(input logic [7:0] m, input logic u,
                              input logic [3:0] br, input logic [3:0] tk);
        valid_i             = 4'hF;
        is_branch_i         = br;
        taken_cf_i          = tk;
        bp_metadata_i       = m;
        serving_unaligned_i = u;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        drive_push(8'hAA, 1'b0, 4'b1111, 4'b0000);
        upd_valid_i = 2'b11;
        cyc();
        cyc();
        #1;
        check("rst_usage", 32'(usage_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_meta0", 32'(bp_metadata_o[0]), 32'h0);
        check("rst_unal", 32'(is_unaligned_o), 32'h0);

        // Taken at slot 1 -> cnt 2
        idle();
        rst_ni = 1'b1;
        drive_push(8'h11, 1'b0, 4'b1111, 4'b0010);
        cyc();
        idle();
        upd_valid_i = 2'b01;
        #1;
        check("p1_usage", 32'(usage_o), 32'd1);
        check("p1_lane0", 32'(bp_metadata_o[0]), 32'h11);
        check("p1_unf", 32'(underflow_o), 32'd0);
        cyc();
        #1;
        check("p1_usage_part", 32'(usage_o), 32'd1);
        check("p1_lane0_again", 32'(bp_metadata_o[0]), 32'h11);
        cyc();
        upd_valid_i = 2'b00;
        #1;
        check("p1_drained", 32'(usage_o), 32'd0);

        // A(cnt1), B(cnt2, unaligned)
        drive_push(8'hA1, 1'b0, 4'b0001, 4'b0000);
        cyc();
        drive_push(8'hB2, 1'b1, 4'b0011, 4'b0000);
        cyc();
        idle();
        upd_valid_i = 2'b11;
        #1;
        check("ab_usage", 32'(usage_o), 32'd2);
        check("ab_lane0", 32'(bp_metadata_o[0]), 32'hA1);
        check("ab_lane1", 32'(bp_metadata_o[1]), 32'hB2);
        check("ab_unal", 32'(is_unaligned_o), 32'b10);
        cyc();
        upd_valid_i = 2'b01;
        #1;
        check("ab_usage_after", 32'(usage_o), 32'd1);
        check("ab_lane0_b", 32'(bp_metadata_o[0]), 32'hB2);
        check("ab_lane1_off", 32'(bp_metadata_o[1]), 32'h0);
        cyc();
        upd_valid_i = 2'b00;
        #1;
        check("ab_empty", 32'(usage_o), 32'd0);

        // Replay from slot 1 plus iq overflow blocks the push
        iq_overflow_i = 1'b1;
        replay_addr_i = 32'h42;
        drive_push(8'hCC, 1'b0, 4'b1111, 4'b0000);
        #1;
        check("iq_ovf_flag", 32'(overflow_o), 32'd0);
        cyc();
        idle();
        #1;
        check("iq_no_push", 32'(usage_o), 32'd0);

        // Fill to 8 across the pointer wrap
        for (int i = 0; i < 8; i++) begin
            drive_push(8'h80 + 8'(i), 1'b0, 4'b0001, 4'b0000);
            cyc();
        end
        idle();
        #1;
        check("full_usage", 32'(usage_o), 32'd8);
        drive_push(8'hFF, 1'b0, 4'b0001, 4'b0000);
        upd_valid_i = 2'b01;
        #1;
        check("full_ovf", 32'(overflow_o), 32'd1);
        check("full_lane0", 32'(bp_metadata_o[0]), 32'h80);
        cyc();
        idle();
        #1;
        check("full_usage7", 32'(usage_o), 32'd7);
        for (int i = 0; i < 3; i++) begin
            upd_valid_i = 2'b11;
            #1;
            check("drain_l0", 32'(bp_metadata_o[0]), 32'h81 + 32'(2 * i));
            check("drain_l1", 32'(bp_metadata_o[1]), 32'h82 + 32'(2 * i));
            cyc();
        end
        upd_valid_i = 2'b01;
        #1;
        check("drain_last", 32'(bp_metadata_o[0]), 32'h87);
        check("drain_usage1", 32'(usage_o), 32'd1);
        cyc();
        idle();
        #1;
        check("drain_dropped", 32'(usage_o), 32'd0);

        // Debug mode: outputs map, state holds
        drive_push(8'h55, 1'b0, 4'b0001, 4'b0000);
        cyc();
        idle();
        debug_mode_i = 1'b1;
        upd_valid_i  = 2'b11;
        #1;
        check("dbg_lane0", 32'(bp_metadata_o[0]), 32'h55);
        check("dbg_lane1", 32'(bp_metadata_o[1]), 32'h0);
        cyc();
        debug_mode_i = 1'b0;
        #1;
        check("dbg_usage", 32'(usage_o), 32'd1);
        check("unf_flag", 32'(underflow_o), 32'd1);
        check("unf_lane0", 32'(bp_metadata_o[0]), 32'h55);
        check("unf_lane1", 32'(bp_metadata_o[1]), 32'h0);
        cyc();
        idle();
        #1;
        check("unf_usage", 32'(usage_o), 32'd0);
        check("unf_clear", 32'(underflow_o), 32'd0);

        // Flush beats a concurrent push
        drive_push(8'h66, 1'b0, 4'b0001, 4'b0000);
        cyc();
        flush_i = 1'b1;
        drive_push(8'h77, 1'b0, 4'b0001, 4'b0000);
        cyc();
        idle();
        #1;
        check("flush_usage", 32'(usage_o), 32'd0);

        // Push and pop in the same cycle
        drive_push(8'h21, 1'b0, 4'b0001, 4'b0000);
        cyc();
        drive_push(8'h22, 1'b0, 4'b0001, 4'b0000);
        upd_valid_i = 2'b01;
        #1;
        check("pp_lane0", 32'(bp_metadata_o[0]), 32'h21);
        cyc();
        idle();
        upd_valid_i = 2'b01;
        #1;
        check("pp_usage", 32'(usage_o), 32'd1);
        check("pp_lane0_next", 32'(bp_metadata_o[0]), 32'h22);
        cyc();
        idle();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/ftq_multi_update.md
Name: ftq_multi_update

Overview:
- Parametrised successor to the frontend fetch target queue.
- Buffers per-fetch-block branch-prediction metadata from the frontend. Returns that metadata to up to NR_UPDATE resolved-branch update ports per cycle.
- Updates may retire branches across several queued entries in the same cycle.
- Sits between the frontend (push side) and the BHT update path (pop side).
- Adds the following over the single-update queue: per-entry remaining-count storage, multi-entry consumption, occupancy output, and an underflow flag.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration (VLEN, INSTR_PER_FETCH, LOG2_INSTR_PER_FETCH).
- bp_metadata_t, logic, predictor metadata payload type.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- NR_UPDATE, 2, number of branch-update lanes per cycle; range 1..4.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_i  in  1  drop all entries
- debug_mode_i  in  1  when high, updates do not consume entries
- replay_addr_i  in  VLEN  instruction-queue replay address
- serving_unaligned_i  in  1  fetch block starts with the second half of an unaligned instruction
- iq_overflow_i  in  1  instruction queue overflowed this cycle
- valid_i  in  INSTR_PER_FETCH  valid instruction slots
- is_branch_i  in  INSTR_PER_FETCH  slot is a conditional branch
- taken_cf_i  in  INSTR_PER_FETCH  slot is a predicted-taken control flow (RVI or RVC)
- bp_metadata_i  in  bp_metadata_t  metadata for the current fetch block
- upd_valid_i  in  NR_UPDATE  resolved branches this cycle; lanes are contiguous from lane 0
- bp_metadata_o  out  NR_UPDATE x bp_metadata_t  metadata for each lane
- is_unaligned_o  out  NR_UPDATE  unaligned flag for each lane
- usage_o  out  clog2(DEPTH)+1  occupied entries
- overflow_o  out  1  push requested while full
- underflow_o  out  1  an update arrived with no matching entry

Behaviour:
- Reset: synchronous, rst_ni low at a clock edge.
  - Head, tail and usage are cleared; all per-entry counts are cleared.
  - After reset, usage_o=0, overflow_o=0, underflow_o=0, and bp_metadata_o and is_unaligned_o are 0.
- Push qualification (combinational):
  - replay_pos = serving_unaligned_i ? 0 : replay_addr_i[LOG2_INSTR_PER_FETCH:1].
  - is_replay = {INSTR_PER_FETCH{iq_overflow_i}} << replay_pos.
  - vb[i] = is_branch_i[i] & ~is_replay[i] & ~|(valid_i & taken_cf_i)[i-1:0]; slot 0 has no prior-taken term.
  - cnt = popcount(vb), width LOG2_INSTR_PER_FETCH+1.
- Push acceptance:
  - A push is accepted iff cnt != 0, usage_q < DEPTH, and iq_overflow_i = 0.
  - The entry {bp_metadata_i, serving_unaligned_i, cnt} is written at the tail.
  - A pushed entry is visible to update lanes from the next cycle; there is no bypass.
  - Fullness uses the start-of-cycle usage: a push while full is rejected even if a pop occurs in the same cycle.
  - overflow_o = (cnt != 0) & (usage_q == DEPTH), combinational.
- Update mapping (combinational):
  - n = popcount(upd_valid_i).
  - Let r0, r1, ... be the remaining counts of entries head, head+1, ... (wrapping modulo DEPTH). Only entries below usage_q are considered.
  - Lane k maps to the smallest j such that k < r0 + ... + rj.
  - bp_metadata_o[k] and is_unaligned_o[k] come from entry head+j.
  - Lanes that map beyond usage_q, and invalid lanes, output 0.
- Consumption, applied when debug_mode_i = 0:
  - n branches are removed starting from the head.
  - Every fully drained entry is popped; the head advances by the number of popped entries, at most NR_UPDATE.
  - In a partially drained entry, the remaining count is decremented in place.
  - If n exceeds the total remaining in the queue, underflow_o pulses for that cycle, the queue empties, and the excess lanes output 0.
  - When debug_mode_i = 1, outputs still map as above, but no state changes.
- Simultaneous push and pop: both apply. usage_d = usage_q + push - pops. Pointers wrap modulo DEPTH.
- Flush has priority over push and pop. The cycle after a flush is asserted: usage_o=0, and a push in the flush cycle is dropped.
- Assertion: upd_valid_i must be contiguous from lane 0 (no 0 below a 1). This is checked in simulation only.
- Latency: outputs are combinational from registered state plus upd_valid_i. State updates in 1 cycle.

Decomposition:
- ftq_pkg holds:
  - the ftq_entry_t struct {bp_metadata_t, is_unaligned, remaining count}, declared parametrically in the module since bp_metadata_t is a parameter;
  - the function for the replay mask;
  - the constant DEPTH_W = clog2(DEPTH).
- One sub-module, ftq_lane_map: takes remaining counts of NR_UPDATE head entries plus usage, and returns per-lane entry offset and the pop count.
- Storage is an in-module register array (no FIFO instance), because per-entry counts are modified in place.
- popcount is reused from the existing common cells.

Test Plan:
- Reset with pushes pending -> usage_o=0; the first push of cnt=2 then shows usage_o=1, and lane 0 metadata equals the pushed value on the next cycle.
- INSTR_PER_FETCH=4, is_branch=1111, taken at slot 1 -> cnt=2. Then upd_valid=01 for two cycles -> the entry pops after the second update, usage back to 0.
- Entries A(cnt=1), B(cnt=2) queued, upd_valid=11 -> lane0=A, lane1=B; head advances by 1; B remaining=1.
- iq_overflow_i=1, replay_addr=0x42, branches in slots 0-3 -> is_replay=1110, no push accepted; overflow_o=0.
- Fill to DEPTH=8, push again -> overflow_o=1, push dropped. Same cycle with an update popping -> usage_o=7 next cycle.
- upd_valid=11 with one entry of remaining 1 -> underflow_o=1, lane1 outputs 0, usage 0. Repeat with debug_mode_i=1 -> no state change. Flush concurrent with push -> usage_o=0.
